// File: rtl/mmu_pkg.sv
// Shared types and limits for the page-table-walker request arbiter.
package mmu_pkg;

    localparam int MAX_NUM_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ptw_rr_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of pending_i strictly after
// last_grant_i, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [ID_W-1:0]    grant_o,
    output logic               any_valid_o
);

    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant_i) + k) % NUM_REQ);
            if (!found && pending_i[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign grant_o     = grant;
    assign any_valid_o = found;

endmodule

// File: rtl/ptw_rr_arb.sv
// Round-robin arbiter holding one outstanding TLB miss per requester in front of the PTW.
// Define PTW_ARB_MERGE_EN to answer every pending requester with the walked VPN from one walk.
//
// state | meaning
// IDLE  | no walk outstanding; pick the next pending requester
// ISSUE | walk request presented to the PTW, waiting for ptw_ready_i
// WAIT  | walk accepted, forward the response to the grantee
// DRAIN | walk accepted then flushed; swallow its response
module ptw_rr_arb
    import mmu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int VPN_W   = 27,
    parameter  int PTE_W   = 64,
    parameter  int LEVEL_W = 2,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*VPN_W-1:0] req_vpn_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       resp_valid_o,
    output logic [PTE_W-1:0]         resp_pte_o,
    output logic [LEVEL_W-1:0]       resp_level_o,
    output logic                     resp_error_o,
    input  logic                     flush_i,
    output logic                     ptw_req_valid_o,
    output logic [VPN_W-1:0]         ptw_req_vpn_o,
    output logic [ID_W-1:0]          ptw_req_id_o,
    input  logic                     ptw_ready_i,
    input  logic                     ptw_resp_valid_i,
    input  logic [PTE_W-1:0]         ptw_resp_pte_i,
    input  logic [LEVEL_W-1:0]       ptw_resp_level_i,
    input  logic                     ptw_resp_error_i
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
        $error("ptw_rr_arb: NUM_REQ out of range");
    end

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [VPN_W-1:0]   vpn_q [NUM_REQ];
    logic [ID_W-1:0]    grant_id_q, last_grant_q;
    logic [ID_W-1:0]    pick_id;
    logic               pick_valid;
    logic [NUM_REQ-1:0] capture, grant_onehot, resp_mask, resp_valid;
    logic               resp_fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .pending_i    (pending_q),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_id),
        .any_valid_o  (pick_valid)
    );

    assign req_ready_o  = ~pending_q & {NUM_REQ{~flush_i}};
    assign capture      = req_valid_i & req_ready_o;
    assign resp_fire    = (state_q == WAIT) && ptw_resp_valid_i && !flush_i;
    assign grant_onehot = NUM_REQ'(1) << grant_id_q;

`ifdef PTW_ARB_MERGE_EN
    logic [NUM_REQ-1:0] same_vpn;

    always_comb begin
        same_vpn = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            same_vpn[i] = pending_q[i] && (vpn_q[i] == vpn_q[grant_id_q]);
        end
    end

    // A faulting walk is only meaningful to the requester that asked for it.
    assign resp_mask = ptw_resp_error_i ? grant_onehot : (grant_onehot | same_vpn);
`else
    assign resp_mask = grant_onehot;
`endif

    assign resp_valid   = resp_fire ? resp_mask : '0;
    assign resp_valid_o = resp_valid;
    assign resp_pte_o   = resp_fire ? ptw_resp_pte_i   : '0;
    assign resp_level_o = resp_fire ? ptw_resp_level_i : '0;
    assign resp_error_o = resp_fire && ptw_resp_error_i;

    assign pending_d = flush_i ? '0 : ((pending_q & ~resp_valid) | capture);

    assign ptw_req_valid_o = (state_q == ISSUE);
    assign ptw_req_vpn_o   = ptw_req_valid_o ? vpn_q[grant_id_q] : '0;
    assign ptw_req_id_o    = grant_id_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_REQ; i++) vpn_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (capture[i]) vpn_q[i] <= req_vpn_i[i*VPN_W +: VPN_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (!flush_i && pick_valid) begin
                        grant_id_q <= pick_id;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An accepted walk cannot be recalled; its response must still be absorbed.
                    if (flush_i)          state_q <= ptw_ready_i ? DRAIN : IDLE;
                    else if (ptw_ready_i) state_q <= WAIT;
                end
                WAIT: begin
                    if (ptw_resp_valid_i) begin
                        state_q <= IDLE;
                        if (!flush_i) last_grant_q <= grant_id_q;
                    end else if (flush_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ptw_resp_valid_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    resp_only_when_walking: assert property (@(posedge clk_i) disable iff (!rstn_i)
        ptw_resp_valid_i |-> (state_q == WAIT || state_q == DRAIN));

endmodule

// File: tb/tb_ptw_rr_arb.sv
// Randomised and directed bench for ptw_rr_arb with a transaction-level reference
// model and a response scoreboard; follows PTW_ARB_MERGE_EN when defined.
module tb_ptw_rr_arb;

    localparam int NUM_REQ = 3;
    localparam int VPN_W   = 27;
    localparam int PTE_W   = 64;
    localparam int LEVEL_W = 2;
    localparam int ID_W    = 2;

    localparam int PH_FREE  = 0;
    localparam int PH_REQ   = 1;
    localparam int PH_WALK  = 2;
    localparam int PH_DRAIN = 3;

    logic                     clk_i;
    logic                     rstn_i;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ*VPN_W-1:0] req_vpn_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ-1:0]       resp_valid_o;
    logic [PTE_W-1:0]         resp_pte_o;
    logic [LEVEL_W-1:0]       resp_level_o;
    logic                     resp_error_o;
    logic                     flush_i;
    logic                     ptw_req_valid_o;
    logic [VPN_W-1:0]         ptw_req_vpn_o;
    logic [ID_W-1:0]          ptw_req_id_o;
    logic                     ptw_ready_i;
    logic                     ptw_resp_valid_i;
    logic [PTE_W-1:0]         ptw_resp_pte_i;
    logic [LEVEL_W-1:0]       ptw_resp_level_i;
    logic                     ptw_resp_error_i;

    ptw_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .VPN_W   (VPN_W),
        .PTE_W   (PTE_W),
        .LEVEL_W (LEVEL_W)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .req_valid_i      (req_valid_i),
        .req_vpn_i        (req_vpn_i),
        .req_ready_o      (req_ready_o),
        .resp_valid_o     (resp_valid_o),
        .resp_pte_o       (resp_pte_o),
        .resp_level_o     (resp_level_o),
        .resp_error_o     (resp_error_o),
        .flush_i          (flush_i),
        .ptw_req_valid_o  (ptw_req_valid_o),
        .ptw_req_vpn_o    (ptw_req_vpn_o),
        .ptw_req_id_o     (ptw_req_id_o),
        .ptw_ready_i      (ptw_ready_i),
        .ptw_resp_valid_i (ptw_resp_valid_i),
        .ptw_resp_pte_i   (ptw_resp_pte_i),
        .ptw_resp_level_i (ptw_resp_level_i),
        .ptw_resp_error_i (ptw_resp_error_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // PTW behaviour knobs
    int rdy_pct   = 100;
    int dly_min   = 0;
    int dly_max   = 0;
    int err_pct   = 0;
    bit fixed_pte = 1'b0;

    // reference model: pending set, stored VPNs, round-robin pointer, walk phase
    bit               m_pend [NUM_REQ];
    logic [VPN_W-1:0] m_vpn  [NUM_REQ];
    int               m_last;
    int               m_gid;
    int               m_phase;

    typedef struct {
        logic [NUM_REQ-1:0] mask;
        logic [PTE_W-1:0]   pte;
        logic [LEVEL_W-1:0] lvl;
        logic               err;
    } resp_t;

    resp_t exp_q [$];
    resp_t exp_r;
    int    grant_log [$];
    bit    ptw_busy = 1'b0;
    int    ptw_dly  = 0;

    function automatic int rr_next();
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (m_pend[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            m_pend[i] = 1'b0;
            m_vpn[i]  = '0;
        end
        m_last  = NUM_REQ - 1;
        m_gid   = 0;
        m_phase = PH_FREE;
    endtask

    task automatic predict_cycle();
        logic [NUM_REQ-1:0] exp_rdy;
        bit                 cap [NUM_REQ];
        resp_t              r;
        int                 nxt;
        exp_rdy = '0;
        for (int i = 0; i < NUM_REQ; i++) exp_rdy[i] = !m_pend[i] && !flush_i;
        chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        chk("ptw_req_valid", 64'(ptw_req_valid_o), 64'(m_phase == PH_REQ));
        if (m_phase == PH_REQ) begin
            chk("ptw_req_id", 64'(ptw_req_id_o), 64'(m_gid));
            chk("ptw_req_vpn", 64'(ptw_req_vpn_o), 64'(m_vpn[m_gid]));
        end
        r.mask = '0;
        r.pte  = ptw_resp_pte_i;
        r.lvl  = ptw_resp_level_i;
        r.err  = ptw_resp_error_i;
        if (m_phase == PH_WALK && ptw_resp_valid_i && !flush_i) begin
            r.mask[m_gid] = 1'b1;
`ifdef PTW_ARB_MERGE_EN
            if (!ptw_resp_error_i) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (m_pend[j] && m_vpn[j] == m_vpn[m_gid]) r.mask[j] = 1'b1;
                end
            end
`endif
            exp_q.push_back(r);
        end
        nxt = rr_next();
        for (int i = 0; i < NUM_REQ; i++) begin
            cap[i] = req_valid_i[i] && !m_pend[i] && !flush_i;
            if (r.mask[i] || flush_i) m_pend[i] = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cap[i]) begin
                m_pend[i] = 1'b1;
                m_vpn[i]  = req_vpn_i[i*VPN_W +: VPN_W];
            end
        end
        case (m_phase)
            PH_FREE: if (!flush_i && nxt >= 0) begin
                m_gid   = nxt;
                m_phase = PH_REQ;
            end
            PH_REQ: begin
                if (ptw_ready_i)  m_phase = flush_i ? PH_DRAIN : PH_WALK;
                else if (flush_i) m_phase = PH_FREE;
            end
            PH_WALK: begin
                if (ptw_resp_valid_i) begin
                    m_phase = PH_FREE;
                    if (!flush_i) m_last = m_gid;
                end else if (flush_i) begin
                    m_phase = PH_DRAIN;
                end
            end
            default: if (ptw_resp_valid_i) m_phase = PH_FREE;
        endcase
    endtask

    // predictor
    initial begin
        model_reset();
        forever begin
            @(negedge clk_i);
            if (!rstn_i) model_reset();
            else         predict_cycle();
        end
    end

    // response monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (rstn_i) begin
                if (exp_q.size() > 0) begin
                    exp_r = exp_q.pop_front();
                    chk("resp_valid", 64'(resp_valid_o), 64'(exp_r.mask));
                    chk("resp_pte", resp_pte_o, exp_r.pte);
                    chk("resp_level", 64'(resp_level_o), 64'(exp_r.lvl));
                    chk("resp_error", 64'(resp_error_o), 64'(exp_r.err));
                end else if (resp_valid_o != '0) begin
                    chk("resp_unexpected", 64'(resp_valid_o), 64'd0);
                end
            end
        end
    end

    // PTW responder
    initial begin
        ptw_ready_i      = 1'b0;
        ptw_resp_valid_i = 1'b0;
        ptw_resp_pte_i   = '0;
        ptw_resp_level_i = '0;
        ptw_resp_error_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            ptw_resp_valid_i = 1'b0;
            ptw_resp_pte_i   = '0;
            ptw_resp_level_i = '0;
            ptw_resp_error_i = 1'b0;
            if (!rstn_i) begin
                ptw_busy = 1'b0;
            end else if (ptw_busy) begin
                if (ptw_dly == 0) begin
                    ptw_resp_valid_i = 1'b1;
                    ptw_resp_pte_i   = fixed_pte ? 64'hABCD : {$urandom, $urandom};
                    ptw_resp_level_i = LEVEL_W'($urandom);
                    ptw_resp_error_i = int'($urandom_range(99, 0)) < err_pct;
                    ptw_busy         = 1'b0;
                end else begin
                    ptw_dly--;
                end
            end
            ptw_ready_i = int'($urandom_range(99, 0)) < rdy_pct;
            @(negedge clk_i);
            if (rstn_i && ptw_req_valid_o && ptw_ready_i) begin
                grant_log.push_back(int'(ptw_req_id_o));
                ptw_busy = 1'b1;
                ptw_dly  = int'($urandom_range(32'(dly_max), 32'(dly_min)));
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int i, input logic [VPN_W-1:0] vpn);
        req_valid_i[i]               = 1'b1;
        req_vpn_i[i*VPN_W +: VPN_W] = vpn;
    endtask

    task automatic do_reset();
        rstn_i      = 1'b0;
        req_valid_i = '0;
        flush_i     = 1'b0;
        cyc();
        cyc();
        rstn_i = 1'b1;
        cyc();
    endtask

    task automatic settle(input int n);
        req_valid_i = '0;
        flush_i     = 1'b0;
        repeat (n) cyc();
    endtask

    int cnt_pv;
    int cnt_rv;

    initial begin
        rstn_i      = 1'b0;
        req_valid_i = '0;
        req_vpn_i   = '0;
        flush_i     = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_req_ready", 64'(req_ready_o), 64'h7);
        chk("reset_ptw_req_valid", 64'(ptw_req_valid_o), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("reset_ptw_req_id", 64'(ptw_req_id_o), 64'd0);
        cyc();
        rstn_i = 1'b1;
        cyc();

        // single request, fixed latency
        rdy_pct = 100; dly_min = 2; dly_max = 2; fixed_pte = 1'b1;
        set_req(0, 27'h1234);
        cyc();
        req_valid_i = '0;
        @(negedge clk_i);
        chk("s1_grant_cycle_no_req", 64'(ptw_req_valid_o), 64'd0);
        cyc();
        @(negedge clk_i);
        chk("s1_req_valid", 64'(ptw_req_valid_o), 64'd1);
        chk("s1_req_id", 64'(ptw_req_id_o), 64'd0);
        chk("s1_req_vpn", 64'(ptw_req_vpn_o), 64'h1234);
        cyc(); cyc(); cyc();
        @(negedge clk_i);
        chk("s1_resp_valid", 64'(resp_valid_o), 64'h1);
        chk("s1_resp_pte", resp_pte_o, 64'hABCD);
        fixed_pte = 1'b0;
        settle(4);

        // fairness: 0 and 1 together, 0 keeps re-requesting
        do_reset();
        dly_min = 1; dly_max = 1;
        grant_log.delete();
        set_req(0, 27'h100);
        set_req(1, 27'h200);
        cyc();
        req_valid_i[1] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (grant_log.size() >= 3) break;
            cyc();
        end
        req_valid_i = '0;
        chk("s2_grants_seen", 64'(grant_log.size() >= 3), 64'd1);
        if (grant_log.size() >= 3) begin
            chk("s2_grant0", 64'(grant_log[0]), 64'd0);
            chk("s2_grant1", 64'(grant_log[1]), 64'd1);
            chk("s2_grant2", 64'(grant_log[2]), 64'd0);
        end
        settle(10);

        // flush while a walk is outstanding and another requester is pending
        dly_min = 8; dly_max = 8;
        set_req(0, 27'h300);
        set_req(1, 27'h400);
        cyc();
        req_valid_i = '0;
        for (int t = 0; t < 20; t++) begin
            if (ptw_busy) break;
            cyc();
        end
        chk("s3_walk_started", 64'(ptw_busy), 64'd1);
        cyc();
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("s3_ready_in_flush", 64'(req_ready_o), 64'd0);
        cyc();
        flush_i = 1'b0;
        cnt_pv = 0;
        cnt_rv = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk_i);
            if (ptw_req_valid_o) cnt_pv++;
            if (resp_valid_o != '0) cnt_rv++;
            cyc();
        end
        chk("s3_no_new_walk", 64'(cnt_pv), 64'd0);
        chk("s3_resp_dropped", 64'(cnt_rv), 64'd0);
        chk("s3_ready_after", 64'(req_ready_o), 64'h7);
        settle(2);

        // PTW stalls: captured VPN must hold while the input VPN moves
        dly_min = 0; dly_max = 1; rdy_pct = 0;
        set_req(2, 27'h777);
        cyc();
        req_vpn_i[2*VPN_W +: VPN_W] = 27'h999;
        cyc();
        for (int t = 0; t < 4; t++) begin
            @(negedge clk_i);
            chk("s4_req_valid", 64'(ptw_req_valid_o), 64'd1);
            chk("s4_vpn_stable", 64'(ptw_req_vpn_o), 64'h777);
            chk("s4_ready2_low", 64'(req_ready_o[2]), 64'd0);
            cyc();
        end
        rdy_pct = 100;
        cyc();
        req_valid_i = '0;
        settle(10);

        // duplicate VPNs, clean walk
        do_reset();
        err_pct = 0; dly_min = 1; dly_max = 1;
        grant_log.delete();
        set_req(0, 27'h55);
        set_req(1, 27'h55);
        cyc();
        req_valid_i = '0;
        repeat (14) cyc();
`ifdef PTW_ARB_MERGE_EN
        chk("s5_walk_count", 64'(grant_log.size()), 64'd1);
`else
        chk("s5_walk_count", 64'(grant_log.size()), 64'd2);
`endif

        // duplicate VPNs, faulting walks are never shared
        do_reset();
        err_pct = 100;
        grant_log.delete();
        set_req(0, 27'h55);
        set_req(1, 27'h55);
        cyc();
        req_valid_i = '0;
        repeat (14) cyc();
        chk("s6_walk_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            chk("s6_first", 64'(grant_log[0]), 64'd0);
            chk("s6_second", 64'(grant_log[1]), 64'd1);
        end

        // random traffic
        rdy_pct = 70; dly_min = 0; dly_max = 4; err_pct = 20;
        for (int t = 0; t < 3000; t++) begin
            if (t == 1500) do_reset();
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid_i[i] = int'($urandom_range(99, 0)) < 35;
                case ($urandom_range(3, 0))
                    0:       req_vpn_i[i*VPN_W +: VPN_W] = 27'h55;
                    1:       req_vpn_i[i*VPN_W +: VPN_W] = 27'h66;
                    default: req_vpn_i[i*VPN_W +: VPN_W] = VPN_W'($urandom);
                endcase
            end
            flush_i = int'($urandom_range(99, 0)) < 2;
            cyc();
        end
        settle(40);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ptw_rr_arb.md
Name: ptw_rr_arb

Overview:
- N-requester round-robin arbiter in front of the single page-table walker. Clients are the iTLB, dTLB and future requesters such as an L2 TLB prefetcher.
- Latches one outstanding miss per requester and issues one walk at a time.
- Routes the walk response back to the granted requester only.
- Supports a global flush that discards queued and in-flight walks (sfence.vma / satp write).

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- VPN_W, 27, virtual page number width (Sv39).
- PTE_W, 64, PTE width.
- LEVEL_W, 2, page level field width.
- Derived localparam: ID_W = max(1, $clog2(NUM_REQ)).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  async active-low reset
- req_valid_i  in  NUM_REQ  per-requester miss request
- req_vpn_i  in  NUM_REQ*VPN_W  per-requester VPN, slot i at [i*VPN_W +: VPN_W]
- req_ready_o  out  NUM_REQ  requester slot free
- resp_valid_o  out  NUM_REQ  one-hot, one-cycle response strobe
- resp_pte_o  out  PTE_W  response PTE, shared by all requesters
- resp_level_o  out  LEVEL_W  response level, shared
- resp_error_o  out  1  page fault / access error, shared
- flush_i  in  1  abort all queued and outstanding walks
- ptw_req_valid_o  out  1  walk request to PTW
- ptw_req_vpn_o  out  VPN_W  walk VPN
- ptw_req_id_o  out  ID_W  granted requester index
- ptw_ready_i  in  1  PTW accepts request
- ptw_resp_valid_i  in  1  walk complete
- ptw_resp_pte_i  in  PTE_W  walk PTE
- ptw_resp_level_i  in  LEVEL_W  walk level
- ptw_resp_error_i  in  1  walk error

Behaviour:
- Reset: all outputs 0 except req_ready_o = all-ones; pending[] = 0; state IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
- Capture: req_valid_i[i] && req_ready_o[i] sets pending[i] and stores vpn[i]. req_ready_o[i] = !pending[i] && !flush_i. A requester holding valid with ready low is ignored, not buffered.
- FSM:
  - IDLE: if any pending, grant = first pending index searching from last_grant+1 with wrap-around mod NUM_REQ; register grant_id; go to ISSUE.
  - ISSUE: ptw_req_valid_o=1, vpn/id from grant_id slot, held stable until ptw_ready_i; on handshake go to WAIT.
  - WAIT: on ptw_resp_valid_i, drive resp_valid_o[grant_id]=1 and pte/level/error for one cycle (combinational pass-through); clear pending[grant_id]; last_grant=grant_id; go to IDLE.
  - DRAIN: wait for ptw_resp_valid_i, drop it (no resp_valid_o), go to IDLE.
- Latency: capture at edge 0 -> IDLE grant cycle 1 -> ptw_req_valid_o from cycle 2. Response forwarded in the same cycle as ptw_resp_valid_i. Back-to-back walks separated by one IDLE cycle.
- A requester whose response is strobed may re-request in the next cycle. It is not eligible before the other pending requesters (round-robin fairness).
- flush_i, highest priority:
  - clears all pending bits.
  - In ISSUE without handshake that cycle: go to IDLE.
  - In ISSUE with handshake that cycle, or in WAIT: go to DRAIN.
  - A flush in the same cycle as ptw_resp_valid_i in WAIT suppresses resp_valid_o and goes to IDLE.
  - New captures are blocked during the flush cycle.
- Responses arriving in IDLE/ISSUE are protocol errors; ignore them (assertion in sim).
- Reset mid-walk returns to the reset state immediately. The PTW is reset by the same rstn_i.

Optional Feature:
- PTW_ARB_MERGE_EN defined:
  - On a forwarded response, every other pending requester whose stored VPN equals the walked VPN also gets resp_valid_o set in the same cycle and its pending bit cleared.
  - Non-error responses only; error responses go to the grantee only.
- Undefined: only grant_id is answered; duplicates walk separately.

Decomposition:
- mmu_pkg: arb state enum (IDLE, ISSUE, WAIT, DRAIN) and the NUM_REQ upper-bound constant.
- One natural sub-module: rr_pick. Combinational round-robin priority picker; inputs pending mask and last_grant; outputs grant index and any_valid. Reusable elsewhere.

Test Plan:
- NUM_REQ=2. req0 vpn 0x1234 at cycle 0; ptw_ready_i=1; response pte 0xABCD at cycle 5 -> ptw_req_valid_o cycle 2 with id 0; resp_valid_o=2'b01 at cycle 5 with pte 0xABCD.
- req0 and req1 same cycle, then req0 re-requests right after its response -> grants in order 0, 1, 0; never 0, 0.
- Flush while in WAIT, req1 pending -> pending cleared; PTW response dropped; resp_valid_o stays 0; FSM returns to IDLE; ptw_req_valid_o stays low afterwards.
- ptw_ready_i held low 4 cycles in ISSUE, req2 vpn changes its input -> ptw_req_vpn_o stable at the captured value; req_ready_o[2]=0 until its response.
- PTW_ARB_MERGE_EN, both requesters vpn 0x55 -> single walk; resp_valid_o=2'b11; both ready again next cycle.
- ptw_resp_error_i=1 with merge enabled -> only the grantee is strobed; the other stays pending and is walked next.
